phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Parametrised phase generator for the multi-cycle RV32I core, replacing the fixed-rotation phase counter that feeds `cstate` to the controller. It sequences IF/DE/EX/WB with a memory-ready handshake, so memories may insert wait states. It also provides run/single-step control, halt on SYSTEM opcodes, a bounded-wait timeout fault, and a retired-instruction counter. The controller stays purely combinational; the datapath qualifies its register loads with `phase_end`.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles per memory phase; 0 disables the timeout.
- `WAIT_W`, default 8: width of the wait counter; must satisfy 2^WAIT_W > TIMEOUT.
- `CNT_W`, default 32: width of `instret`.

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; enables continuous execution.
- `step_mode` in 1: when 1, one instruction is executed per `step` rising edge.
- `step` in 1: step request; edge-detected internally.
- `opcode` in 7: `ir[6:0]` from the IR register.
- `mem_ready` in 1: memory completion for the current request.
- `cstate` out 4: one-hot phase. IF=0001, DE=0010, EX=0100, WB=1000. 0000 in IDLE, HALT and FAULT.
- `mem_req` out 1: a memory access is outstanding in this phase.
- `phase_end` out 1: last cycle of the current phase; datapath loads are enabled only here.
- `wait_cnt` out WAIT_W: wait cycles spent in the current phase.
- `instret` out CNT_W: retired instruction count; wraps modulo 2^CNT_W.
- `halted` out 1: sticky; set by a SYSTEM opcode.
- `fault` out 1: sticky; set by a memory timeout.

## Operation
- States: IDLE, IF, DE, EX, WB, HALT, FAULT.
- Reset: state IDLE; every output is 0, including `instret`, `wait_cnt` and the `step` edge register.
- IDLE → IF when `run` and either `!step_mode` or a `step` rise is seen this cycle (`step` high now, low in the previous cycle). Otherwise remain in IDLE.
- IF: `mem_req`=1.
  - `mem_ready`=1: `phase_end`=1; next state DE.
  - `mem_ready`=0: `wait_cnt` increments.
- DE and EX: one cycle each, with `phase_end`=1. DE → EX → WB.
- WB:
  - If `opcode` is 0000011 (load) or 0100011 (store): `mem_req`=1 and the same wait rule as IF applies.
  - Otherwise WB completes in one cycle.
  - On completion (`phase_end`=1), `instret` increments by 1.
  - Next state, in priority order:
    1. HALT if `opcode`=1110011.
    2. IDLE if `step_mode` or `!run`.
    3. IF otherwise.
- Timeout: applies when `TIMEOUT`≠0, in a memory phase with `mem_ready`=0 and `wait_cnt`=TIMEOUT-1. Next state is FAULT; `phase_end` stays 0; `instret` is unchanged.
- `mem_ready`=1 in the timeout cycle completes the phase normally; ready wins.
- `wait_cnt` clears to 0 on every phase entry.
- `mem_ready` outside a memory phase is ignored.
- HALT: `halted`=1 and the state holds until `reset`. FAULT behaves the same way with `fault`=1. `run` and `step` are ignored in both.
- `run` deasserted mid-instruction: the instruction completes through WB, then the sequencer enters IDLE.
- Switching `step_mode` mid-instruction takes effect at the WB decision.
- `opcode` is sampled only in WB; it is stable there because IR loads only at IF `phase_end`.

## Timing
- All outputs are registered state decodes, or combinational from state plus `mem_ready`/`opcode`. `phase_end` and `mem_req` are combinational.
- From `run` rising in IDLE, IF appears on the next edge (1 cycle).
- A zero-wait non-memory instruction takes 4 cycles, IF→WB. With `run` held, IF is re-entered on the cycle after WB, so there is no IDLE bubble.
- Each memory wait cycle adds exactly 1 cycle to its phase.
- `instret` updates on the edge that ends WB.
- `halted` and `fault` assert on the edge entering HALT or FAULT.
- `reset` in any state, including mid-wait, gives IDLE with all outputs 0 after that edge.

## Test plan
- **Free-run, zero wait.** `run`=1, `mem_ready`=1, `opcode`=0010011, for 12 cycles. Expect `cstate` 0001,0010,0100,1000 repeating, `instret`=3, `phase_end` high every cycle.
- **IF wait states.** `mem_ready` held low for 3 cycles in IF. Expect IF to last 4 cycles, `wait_cnt` to read 0,1,2,3, and `phase_end` high only in the 4th cycle.
- **Load in WB with timeout.** `TIMEOUT`=4, `opcode`=0000011, `mem_ready`=0 in WB. Expect FAULT after 4 WB cycles, `fault`=1, `cstate`=0000, `instret` unchanged. A second run with `mem_ready`=1 in the timeout cycle must reach IF instead.
- **Single-step.** `step_mode`=1, `step` held high for 10 cycles. Expect exactly one instruction (`instret` +1), then IDLE. A second rising edge runs one more.
- **SYSTEM halt.** `opcode`=1110011 at WB. Expect HALT, `halted`=1, `instret` incremented. `run`/`step` toggling has no effect; `reset` returns to IDLE with all outputs 0.
- **Reset mid-wait and counter wrap.** `reset` during an IF wait gives IDLE and `wait_cnt`=0 after the next edge. With `CNT_W`=4, 17 instructions give `instret`=1.

Source files
------------

// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle RV32I core: IF/DE/EX/WB with memory wait
// states, run/single-step control, SYSTEM halt, wait timeout and retire counter.
module phase_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step_mode,
    input  logic              step,
    input  logic [6:0]        opcode,
    input  logic              mem_ready,
    output logic [3:0]        cstate,
    output logic              mem_req,
    output logic              phase_end,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0]  instret,
    output logic              halted,
    output logic              fault
);

    // state   | meaning
    // S_IDLE  | waiting for run (or a step edge in step mode)
    // S_IF    | instruction fetch, memory phase
    // S_DE    | decode, one cycle
    // S_EX    | execute, one cycle
    // S_WB    | writeback; memory phase for loads/stores, retires instruction
    // S_HALT  | SYSTEM opcode seen, held until reset
    // S_FAULT | memory timeout, held until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_DE,
        S_EX,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [6:0] LP_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] LP_OP_STORE  = 7'b0100011;
    localparam logic [6:0] LP_OP_SYSTEM = 7'b1110011;
    localparam logic [WAIT_W-1:0] LP_TMO_LAST =
        (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_step_d;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_instret;
    logic                w_step_rise;
    logic                w_is_mem_op;
    logic                w_tmo_hit;
    logic                w_retire;
    logic                w_wb_done;

    assign w_step_rise = step & ~r_step_d;
    assign w_is_mem_op = (opcode == LP_OP_LOAD) || (opcode == LP_OP_STORE);
    // Only meaningful in a memory phase with mem_ready low; checked in the FSM.
    assign w_tmo_hit   = (TIMEOUT != 0) && (r_wait_cnt == LP_TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cstate      = 4'b0000;
        mem_req     = 1'b0;
        phase_end   = 1'b0;
        w_retire    = 1'b0;
        w_wb_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run && (!step_mode || w_step_rise)) begin
                    w_state_nxt = S_IF;
                end
            end
            S_IF: begin
                cstate  = 4'b0001;
                mem_req = 1'b1;
                if (mem_ready) begin
                    phase_end   = 1'b1;
                    w_state_nxt = S_DE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_DE: begin
                cstate      = 4'b0010;
                phase_end   = 1'b1;
                w_state_nxt = S_EX;
            end
            S_EX: begin
                cstate      = 4'b0100;
                phase_end   = 1'b1;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                cstate = 4'b1000;
                if (w_is_mem_op) begin
                    mem_req   = 1'b1;
                    w_wb_done = mem_ready;
                end else begin
                    w_wb_done = 1'b1;
                end
                if (w_wb_done) begin
                    phase_end = 1'b1;
                    w_retire  = 1'b1;
                    if (opcode == LP_OP_SYSTEM) begin
                        w_state_nxt = S_HALT;
                    end else if (step_mode || !run) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_IF;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait count survives only while a memory phase stalls in place; any
    // phase change (including entry to FAULT) starts it from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (mem_req && !mem_ready && (w_state_nxt == r_state)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instret <= '0;
            r_step_d  <= 1'b0;
        end else begin
            r_step_d <= step;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign wait_cnt = r_wait_cnt;
    assign instret  = r_instret;
    assign halted   = (r_state == S_HALT);
    assign fault    = (r_state == S_FAULT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (TIMEOUT=4, CNT_W=4): per-cycle vector
// table plus a free-run sequence exercising retire counter wrap.
module tb_phase_sequencer;

    localparam int TIMEOUT = 4;
    localparam int WAIT_W  = 3;
    localparam int CNT_W   = 4;

    localparam logic [6:0] OP_ALU = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [3:0] C_NO = 4'b0000;
    localparam logic [3:0] C_IF = 4'b0001;
    localparam logic [3:0] C_DE = 4'b0010;
    localparam logic [3:0] C_EX = 4'b0100;
    localparam logic [3:0] C_WB = 4'b1000;

    logic              clock = 1'b0;
    logic              reset;
    logic              run;
    logic              step_mode;
    logic              step;
    logic [6:0]        opcode;
    logic              mem_ready;
    logic [3:0]        cstate;
    logic              mem_req;
    logic              phase_end;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret;
    logic              halted;
    logic              fault;

    int checks = 0;
    int errors = 0;

    phase_sequencer #(
        .TIMEOUT (TIMEOUT),
        .WAIT_W  (WAIT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .step_mode (step_mode),
        .step      (step),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .cstate    (cstate),
        .mem_req   (mem_req),
        .phase_end (phase_end),
        .wait_cnt  (wait_cnt),
        .instret   (instret),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       run;
        logic       sm;
        logic       stp;
        logic [6:0] op;
        logic       rdy;
        logic [3:0] cs;
        logic       req;
        logic       pe;
        logic [2:0] wc;
        logic [3:0] ir;
        logic       h;
        logic       f;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic r, input logic sm, input logic stp,
                       input logic [6:0] op, input logic rdy, input logic [3:0] cs,
                       input logic req, input logic pe, input logic [2:0] wc,
                       input logic [3:0] ir, input logic h, input logic f);
        vec_t v;
        v.rst = rst; v.run = r; v.sm = sm; v.stp = stp; v.op = op; v.rdy = rdy;
        v.cs = cs; v.req = req; v.pe = pe; v.wc = wc; v.ir = ir; v.h = h; v.f = f;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_out(input logic [3:0] cs, input logic req,
                                              input logic pe, input logic [2:0] wc,
                                              input logic [3:0] ir, input logic h,
                                              input logic f);
        return {cs, req, pe, wc, ir, h, f, 1'b0};
    endfunction

    initial begin
        // rst run sm stp op rdy | cs req pe wc ir h f
        // free run, zero wait: 12 cycles after IDLE give 3 retirements
        add(0,1,0,0,OP_ALU,1, C_NO,0,0,0,0,0,0);
        for (int k = 0; k < 3; k++) begin
            add(0,1,0,0,OP_ALU,1, C_IF,1,1,0,4'(k),0,0);
            add(0,1,0,0,OP_ALU,1, C_DE,0,1,0,4'(k),0,0);
            add(0,1,0,0,OP_ALU,1, C_EX,0,1,0,4'(k),0,0);
            add(0,1,0,0,OP_ALU,1, C_WB,0,1,0,4'(k),0,0);
        end
        // IF waits 3 cycles; mem_ready ignored in DE/EX; load waits 1 in WB
        add(0,1,0,0,OP_ALU,0, C_IF,1,0,0,3,0,0);
        add(0,1,0,0,OP_ALU,0, C_IF,1,0,1,3,0,0);
        add(0,1,0,0,OP_ALU,0, C_IF,1,0,2,3,0,0);
        add(0,1,0,0,OP_ALU,1, C_IF,1,1,3,3,0,0);
        add(0,1,0,0,OP_ALU,0, C_DE,0,1,0,3,0,0);
        add(0,1,0,0,OP_ALU,0, C_EX,0,1,0,3,0,0);
        add(0,1,0,0,OP_LD ,0, C_WB,1,0,0,3,0,0);
        add(0,1,0,0,OP_LD ,1, C_WB,1,1,1,3,0,0);
        // run dropped mid-instruction: completes, then IDLE
        add(0,0,0,0,OP_ALU,1, C_IF,1,1,0,4,0,0);
        add(0,0,0,0,OP_ALU,1, C_DE,0,1,0,4,0,0);
        add(0,0,0,0,OP_ALU,1, C_EX,0,1,0,4,0,0);
        add(0,0,0,0,OP_ALU,1, C_WB,0,1,0,4,0,0);
        add(0,0,0,0,OP_ALU,1, C_NO,0,0,0,5,0,0);
        add(0,0,0,0,OP_ALU,1, C_NO,0,0,0,5,0,0);
        // single step: held step runs one instruction, second edge runs one more
        add(0,1,1,0,OP_ALU,1, C_NO,0,0,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_NO,0,0,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_IF,1,1,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_DE,0,1,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_EX,0,1,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_WB,0,1,0,5,0,0);
        add(0,1,1,1,OP_ALU,1, C_NO,0,0,0,6,0,0);
        add(0,1,1,0,OP_ALU,1, C_NO,0,0,0,6,0,0);
        add(0,1,1,1,OP_ALU,1, C_NO,0,0,0,6,0,0);
        add(0,1,1,1,OP_ALU,1, C_IF,1,1,0,6,0,0);
        add(0,1,1,1,OP_ALU,1, C_DE,0,1,0,6,0,0);
        add(0,1,1,1,OP_ALU,1, C_EX,0,1,0,6,0,0);
        add(0,1,1,1,OP_ALU,1, C_WB,0,1,0,6,0,0);
        // load with ready arriving in the timeout cycle: completes normally
        add(0,1,0,0,OP_ALU,1, C_NO,0,0,0,7,0,0);
        add(0,1,0,0,OP_ALU,1, C_IF,1,1,0,7,0,0);
        add(0,1,0,0,OP_ALU,1, C_DE,0,1,0,7,0,0);
        add(0,1,0,0,OP_ALU,1, C_EX,0,1,0,7,0,0);
        add(0,1,0,0,OP_LD ,0, C_WB,1,0,0,7,0,0);
        add(0,1,0,0,OP_LD ,0, C_WB,1,0,1,7,0,0);
        add(0,1,0,0,OP_LD ,0, C_WB,1,0,2,7,0,0);
        add(0,1,0,0,OP_LD ,1, C_WB,1,1,3,7,0,0);
        // store never ready: FAULT after 4 WB cycles, instret unchanged
        add(0,1,0,0,OP_ALU,1, C_IF,1,1,0,8,0,0);
        add(0,1,0,0,OP_ALU,1, C_DE,0,1,0,8,0,0);
        add(0,1,0,0,OP_ALU,1, C_EX,0,1,0,8,0,0);
        add(0,1,0,0,OP_ST ,0, C_WB,1,0,0,8,0,0);
        add(0,1,0,0,OP_ST ,0, C_WB,1,0,1,8,0,0);
        add(0,1,0,0,OP_ST ,0, C_WB,1,0,2,8,0,0);
        add(0,1,0,0,OP_ST ,0, C_WB,1,0,3,8,0,0);
        add(0,1,0,0,OP_ST ,0, C_NO,0,0,0,8,0,1);
        add(0,0,0,1,OP_ALU,1, C_NO,0,0,0,8,0,1);
        add(1,1,0,0,OP_ALU,1, C_NO,0,0,0,8,0,1);
        add(0,0,0,0,OP_ALU,1, C_NO,0,0,0,0,0,0);
        // SYSTEM opcode halts after retiring; run/step ignored; reset clears
        add(0,1,0,0,OP_ALU,1, C_NO,0,0,0,0,0,0);
        add(0,1,0,0,OP_ALU,1, C_IF,1,1,0,0,0,0);
        add(0,1,0,0,OP_ALU,1, C_DE,0,1,0,0,0,0);
        add(0,1,0,0,OP_ALU,1, C_EX,0,1,0,0,0,0);
        add(0,1,0,0,OP_SYS,1, C_WB,0,1,0,0,0,0);
        add(0,1,0,0,OP_SYS,1, C_NO,0,0,0,1,1,0);
        add(0,0,1,1,OP_SYS,0, C_NO,0,0,0,1,1,0);
        add(0,1,0,0,OP_SYS,1, C_NO,0,0,0,1,1,0);
        add(1,1,0,0,OP_SYS,1, C_NO,0,0,0,1,1,0);
        add(0,0,0,0,OP_ALU,1, C_NO,0,0,0,0,0,0);
        // reset during an IF wait
        add(0,1,0,0,OP_ALU,0, C_NO,0,0,0,0,0,0);
        add(0,1,0,0,OP_ALU,0, C_IF,1,0,0,0,0,0);
        add(0,1,0,0,OP_ALU,0, C_IF,1,0,1,0,0,0);
        add(1,1,0,0,OP_ALU,0, C_IF,1,0,2,0,0,0);
        add(0,0,0,0,OP_ALU,0, C_NO,0,0,0,0,0,0);

        reset = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        opcode = OP_ALU; mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state",
              32'(pack_out(cstate, mem_req, phase_end, wait_cnt, instret, halted, fault)),
              32'(pack_out(C_NO,0,0,0,0,0,0)));

        foreach (vq[i]) begin
            @(negedge clock);
            reset = vq[i].rst; run = vq[i].run; step_mode = vq[i].sm;
            step = vq[i].stp; opcode = vq[i].op; mem_ready = vq[i].rdy;
            #1;
            check($sformatf("vec%0d", i),
                  32'(pack_out(cstate, mem_req, phase_end, wait_cnt, instret, halted, fault)),
                  32'(pack_out(vq[i].cs, vq[i].req, vq[i].pe, vq[i].wc, vq[i].ir,
                               vq[i].h, vq[i].f)));
        end

        // Counter wrap: instruction k enters IF on edge 1+4(k-1) from IDLE
        @(negedge clock);
        reset = 1'b0; run = 1'b1; step_mode = 1'b0; step = 1'b0;
        opcode = OP_ALU; mem_ready = 1'b1;
        repeat (61) @(posedge clock);
        #1;
        check("wrap_if16_cs", 32'(cstate), 32'(C_IF));
        check("wrap_if16_ir", 32'(instret), 32'd15);
        repeat (4) @(posedge clock);
        #1;
        check("wrap_if17_ir", 32'(instret), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        check("wrap_if18_cs", 32'(cstate), 32'(C_IF));
        check("wrap_17_retired", 32'(instret), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
